seq_responder: RTL

- Protocol responder that drives the response side of the start/a/b/stop handshake used by the team's SVA sequence-composition checkers.
- On a rising edge of start, it produces exactly one of two legal responses:
  - fast path: a high two edges later;
  - slow path: b high one edge later, then stop high STOP_GAP edges after b.
- It sits opposite the `$rose(start) |=> (##1 a) or (b ##2 stop)` style assertions and is the DUT those assertions bind to.

---
 rtl/seq_resp_pkg.sv | 16 +
 rtl/seq_responder.sv | 97 +++++++++
 2 files changed

// File: rtl/seq_resp_pkg.sv
// seq_responder shared types: FSM state enum and gap counter width.
// Imported by the responder top.
package seq_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FAST_WAIT,
    S_FAST_A,
    S_SLOW_B,
    S_SLOW_GAP,
    S_SLOW_STOP
  } resp_state_e;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/seq_responder.sv
// Responder for the start / a / b / stop handshake: one response per rise
// of start (fast: a, slow: b then stop), counting rises dropped while busy.
// Ports: clk, rst_n (async low), start, path_sel in; a, b, stop, busy,
// done, drop_cnt[CNT_W] out.
module seq_responder
  import seq_resp_pkg::*;
#(
  parameter int STOP_GAP = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             path_sel,
  output logic             a,
  output logic             b,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] drop_cnt
);

  if (STOP_GAP < 1 || STOP_GAP > 15) begin : g_bad_gap
    $error("seq_responder: STOP_GAP must be 1..15");
  end

  // Cycles spent in SLOW_GAP beyond the first one.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    GAP_CNT_W'((STOP_GAP > 1) ? STOP_GAP - 2 : 0);

  resp_state_e            r_state;
  resp_state_e            w_state_nxt;
  logic                   r_start_q;
  logic [GAP_CNT_W-1:0]   r_gap;
  logic [GAP_CNT_W-1:0]   w_gap_nxt;
  logic [CNT_W-1:0]       r_drop;
  logic [CNT_W-1:0]       w_drop_nxt;
  logic                   w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_state   <= S_IDLE;
      r_gap     <= '0;
      r_drop    <= '0;
    end else begin
      r_start_q <= start;
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  always_comb begin
    w_rise      = start & ~r_start_q;
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_drop_nxt  = r_drop;

    // Any rise seen outside IDLE, terminal states included, is dropped.
    if (w_rise && r_state != S_IDLE && r_drop != '1)
      w_drop_nxt = r_drop + CNT_W'(1);

    case (r_state)
      S_IDLE: begin
        if (w_rise)
          w_state_nxt = path_sel ? S_SLOW_B : S_FAST_WAIT;
      end
      S_FAST_WAIT: w_state_nxt = S_FAST_A;
      S_FAST_A:    w_state_nxt = S_IDLE;
      S_SLOW_B: begin
        if (STOP_GAP > 1) begin
          w_state_nxt = S_SLOW_GAP;
          w_gap_nxt   = GAP_LOAD;
        end else begin
          w_state_nxt = S_SLOW_STOP;
        end
      end
      S_SLOW_GAP: begin
        if (r_gap != '0)
          w_gap_nxt = r_gap - GAP_CNT_W'(1);
        else
          w_state_nxt = S_SLOW_STOP;
      end
      S_SLOW_STOP: w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  assign a        = (r_state == S_FAST_A);
  assign b        = (r_state == S_SLOW_B);
  assign stop     = (r_state == S_SLOW_STOP);
  assign done     = a | stop;
  assign busy     = (r_state != S_IDLE);
  assign drop_cnt = r_drop;

endmodule
